// File: rtl/xt_bus_target_pkg.sv
// Shared definitions for the XT I/O channel target: register offsets,
// CTRL/STATUS bit positions and the bus cycle type.
package xt_bus_target_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_WAIT   = 2'd3;

    localparam int CTRL_DMA_EN  = 0;
    localparam int CTRL_DMA_DIR = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_CLEAR   = 3;

    localparam int STAT_RX_NE   = 0;
    localparam int STAT_TX_FULL = 1;
    localparam int STAT_TC      = 2;
    localparam int STAT_IRQ     = 3;
    localparam int STAT_OVF     = 4;

    typedef enum logic [2:0] {
        IDLE,
        IO_RD,
        IO_WR,
        DMA_RD,
        DMA_WR
    } cycle_t;

endpackage

// File: rtl/xt_io_fifo.sv
// Synchronous byte FIFO with head-of-queue output; pushes to a full FIFO
// and pops from an empty one are dropped.
module xt_io_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/xt_bus_target.sv
// XT I/O channel expansion target: 4-port register window, RX/TX byte FIFOs,
// single-mode DMA handshake, wait-state insertion and terminal-count IRQ.
module xt_bus_target
    import xt_bus_target_pkg::*;
#(
    parameter logic [9:0] BASE  = 10'h300,
    parameter int         DEPTH = 8,
    parameter int         AW    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  data_bus,
    output logic [7:0]  data_bus_ext,
    output logic        data_bus_ext_oe,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        address_enable_n,
    input  logic        dma_acknowledge_n,
    input  logic        terminal_count_n,
    output logic        io_channel_ready,
    output logic        dma_request,
    output logic        interrupt_request,
    input  logic        rx_push,
    input  logic [7:0]  rx_data,
    output logic        rx_full,
    input  logic        tx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_empty
);
    // cycle  | meaning
    // IDLE   | no selected bus cycle in progress
    // IO_RD  | CPU read of the register window
    // IO_WR  | CPU write of the register window
    // DMA_RD | DACK read, device to memory (drains RX)
    // DMA_WR | DACK write, memory to device (fills TX)
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    cycle_t      cyc, start;
    logic        ior_q, iow_q, armed;
    logic [1:0]  off_q, sel_off;
    logic        pop_q;
    logic [2:0]  ctrl, wait_cfg, wait_cnt;
    logic        tc_seen, overflow;
    logic        rd_fall, wr_fall, rd_rise, wr_rise;
    logic        in_window, dma_cyc, commit, dma_commit;
    logic        rx_pop, tx_push;
    logic [7:0]  rx_head, rd_val, status;
    logic        rx_empty, tx_full;
    logic [AW:0] rx_count, tx_count;
    logic        unused_addr;

    // armed stays low for the first clock after reset so a strobe that is
    // already low when reset releases never looks like a falling edge
    assign rd_fall     = armed && ior_q && !io_read_n;
    assign wr_fall     = armed && iow_q && !io_write_n;
    assign rd_rise     = !ior_q && io_read_n;
    assign wr_rise     = !iow_q && io_write_n;
    assign in_window   = address_enable_n && (address[9:2] == BASE[9:2]);
    assign dma_cyc     = !dma_acknowledge_n;
    assign sel_off     = dma_cyc ? REG_DATA : address[1:0];
    assign unused_addr = ^address[19:10];

    assign status = {3'b000, overflow, interrupt_request, tc_seen, tx_full, !rx_empty};

    always_comb begin
        start = IDLE;
        if (cyc == IDLE) begin
            if (rd_fall) begin
                if (dma_cyc)        start = ctrl[CTRL_DMA_DIR] ? IDLE : DMA_RD;
                else if (in_window) start = IO_RD;
            end else if (wr_fall) begin
                if (dma_cyc)        start = ctrl[CTRL_DMA_DIR] ? DMA_WR : IDLE;
                else if (in_window) start = IO_WR;
            end
        end
    end

    always_comb begin
        rd_val = 8'hFF;
        case (sel_off)
            REG_DATA:   rd_val = rx_empty ? 8'hFF : rx_head;
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = {5'b0, ctrl};
            REG_WAIT:   rd_val = {5'b0, wait_cfg};
        endcase
    end

    assign commit     = ((cyc == IO_RD || cyc == DMA_RD) && rd_rise) ||
                        ((cyc == IO_WR || cyc == DMA_WR) && wr_rise);
    assign dma_commit = commit && (cyc == DMA_RD || cyc == DMA_WR);
    assign rx_pop     = commit && pop_q;
    assign tx_push    = commit && (cyc == DMA_WR || (cyc == IO_WR && off_q == REG_DATA));

    xt_io_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    xt_io_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .din(data_bus),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            armed             <= 1'b0;
            ior_q             <= 1'b1;
            iow_q             <= 1'b1;
            cyc               <= IDLE;
            off_q             <= REG_DATA;
            pop_q             <= 1'b0;
            ctrl              <= '0;
            wait_cfg          <= '0;
            wait_cnt          <= '0;
            tc_seen           <= 1'b0;
            overflow          <= 1'b0;
            data_bus_ext      <= '0;
            data_bus_ext_oe   <= 1'b0;
            io_channel_ready  <= 1'b1;
            dma_request       <= 1'b0;
            interrupt_request <= 1'b0;
        end else begin
            armed <= 1'b1;
            ior_q <= io_read_n;
            iow_q <= io_write_n;

            if (start != IDLE) begin
                cyc   <= start;
                off_q <= sel_off;
                // RX is only drained here, so non-empty now means non-empty at commit
                pop_q <= (start == IO_RD || start == DMA_RD) && sel_off == REG_DATA && !rx_empty;
                if (start == IO_RD || start == DMA_RD) begin
                    data_bus_ext    <= rd_val;
                    data_bus_ext_oe <= 1'b1;
                end
                wait_cnt         <= wait_cfg;
                io_channel_ready <= (wait_cfg == 3'd0);
            end else begin
                if (commit) begin
                    cyc             <= IDLE;
                    pop_q           <= 1'b0;
                    data_bus_ext_oe <= 1'b0;
                end
                if (wait_cnt != 3'd0) begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) io_channel_ready <= 1'b1;
                end
            end

            if (commit && cyc == IO_WR) begin
                case (off_q)
                    REG_DATA: if (tx_full) overflow <= 1'b1;
                    REG_CTRL: begin
                        ctrl <= data_bus[2:0];
                        if (data_bus[CTRL_CLEAR]) begin
                            tc_seen           <= 1'b0;
                            overflow          <= 1'b0;
                            interrupt_request <= 1'b0;
                        end
                    end
                    REG_WAIT: wait_cfg <= data_bus[2:0];
                    default: ;
                endcase
            end
            if (commit && cyc == DMA_WR && tx_full) overflow <= 1'b1;

            // placed last so a terminal count wins over a same-cycle CTRL write
            if (dma_commit && !terminal_count_n) begin
                tc_seen            <= 1'b1;
                ctrl[CTRL_DMA_EN]  <= 1'b0;
                if (ctrl[CTRL_IRQ_EN]) interrupt_request <= 1'b1;
            end

            if (!dma_acknowledge_n || cyc == DMA_RD || cyc == DMA_WR)
                dma_request <= 1'b0;
            else
                dma_request <= ctrl[CTRL_DMA_EN] &&
                               (ctrl[CTRL_DMA_DIR] ? (tx_count != DEPTH_C) : (rx_count != '0));
        end
    end

endmodule

// File: doc/xt_bus_target.md
Name: xt_bus_target

Overview:
- Expansion-side responder for the XT I/O channel. It is the slave end of the command strobes, AEN, DACK and TC that the chipset drives.
- Decodes a 4-port I/O window and exposes two byte FIFOs to a local engine:
  - RX: local to host.
  - TX: host to local.
- Runs single-mode 8237 DMA through DRQ/DACK/TC.
- Inserts programmable wait states via io_channel_ready and raises an IRQ on terminal count.

Parameters:
- BASE, 10'h300, I/O base; 4-byte aligned; decodes address[9:2]==BASE[9:2].
- DEPTH, 8, entries per FIFO; power of two.
- AW, 3, log2(DEPTH).

Ports:
- clock  in  1  system clock; all bus inputs synchronous to it.
- reset  in  1  synchronous, active-high.
- address  in  20  bus address.
- data_bus  in  8  host write data.
- data_bus_ext  out  8  read data to host.
- data_bus_ext_oe  out  1  high while this block drives data_bus_ext.
- io_read_n  in  1  IOR strobe.
- io_write_n  in  1  IOW strobe.
- address_enable_n  in  1  1 = CPU cycle (I/O decode allowed); 0 = DMA cycle.
- dma_acknowledge_n  in  1  DACK of the assigned channel.
- terminal_count_n  in  1  TC from the DMA controller.
- io_channel_ready  out  1  0 inserts wait states.
- dma_request  out  1  DRQ.
- interrupt_request  out  1  IRQ, level.
- rx_push  in  1  local write into RX.
- rx_data  in  8  RX write data.
- rx_full  out  1  RX full.
- tx_pop  in  1  local read from TX.
- tx_data  out  8  TX head.
- tx_empty  out  1  TX empty.

Behaviour:
- Reset values:
  - All FIFOs empty; CTRL=0; WAIT=0; tc_seen=0; overflow=0.
  - data_bus_ext=0; data_bus_ext_oe=0; io_channel_ready=1; dma_request=0; interrupt_request=0.
  - Strobe history registers = 1; active flags = 0.
- Cycle detection:
  - Register io_read_n and io_write_n each clock.
  - A falling edge starts a cycle.
  - The cycle is "selected" if:
    - the window matches and address_enable_n=1 (CPU cycle), or
    - dma_acknowledge_n=0 (DMA cycle).
  - Selection is latched into an active flag.
  - A rising edge with the flag set commits the cycle and clears the flag.
  - A strobe already low when reset releases is ignored.
- Register map (offsets; DMA cycles ignore address):
  - 0 DATA:
    - Read returns the RX head, popped at commit; empty returns 8'hFF with no pop.
    - Write pushes data_bus into TX at commit; if TX is full, the byte is dropped and overflow=1.
  - 1 STATUS (read-only): bit0 rx_not_empty, bit1 tx_full, bit2 tc_seen, bit3 interrupt_request, bit4 overflow, bits7:5=0.
  - 2 CTRL:
    - bit0 dma_en; bit1 dma_dir (0 = device to memory, drains RX; 1 = memory to device, fills TX); bit2 irq_en.
    - Writing bit3=1 clears tc_seen and overflow; bit3 is self-clearing and not stored.
    - Read returns {5'b0, bits2:0}.
  - 3 WAIT: bits2:0 set the wait-state count; read returns {5'b0, WAIT}.
- Read data path:
  - The read value is latched on the falling edge.
  - data_bus_ext_oe=1 from the clock after the falling edge until the strobe rises.
  - Data is stable for the whole strobe even if a local push occurs.
- Wait states: on a selected falling edge, io_channel_ready goes 0 for exactly WAIT clocks, then returns to 1. WAIT=0 never deasserts it.
- DMA:
  - dma_request=1 when dma_en and DACK is high and either:
    - dir=0 and RX is non-empty, or
    - dir=1 and TX is not full.
  - DRQ drops the clock after DACK is sampled low and is re-evaluated only after DACK returns high.
  - dir=0: responds to IOR+DACK using the read path with the RX head, popped at commit.
  - dir=1: responds to IOW+DACK by capturing data_bus at commit into TX.
  - A DMA strobe in the wrong direction is ignored.
- Terminal count: if terminal_count_n=0 during any DMA commit:
  - tc_seen=1 and dma_en=0.
  - If irq_en=1, interrupt_request=1, held until clear.
- FIFOs:
  - Simultaneous push and pop in the same clock both take effect; count is unchanged.
  - A push to a full FIFO is dropped; a pop from an empty FIFO is a no-op.
  - rx_push while rx_full is dropped silently.
  - Pointers wrap modulo DEPTH.
- Commit priority: a bus commit and a local push/pop in the same cycle both apply. A CTRL write and a TC event in the same cycle resolve as follows:
  - dma_en=0, whatever was written.
  - tc_seen is set, even if the write carried clear bit3.

Decomposition:
- Package xt_bus_target_pkg:
  - Register offsets: REG_DATA, REG_STATUS, REG_CTRL, REG_WAIT.
  - CTRL and STATUS bit-index constants.
  - Cycle-type enum: IDLE, IO_RD, IO_WR, DMA_RD, DMA_WR.
- Sub-module xt_io_fifo: synchronous FIFO with push, pop, din, dout (head), full, empty, count. Instantiated twice, for RX and TX.

Test Plan:
- Local pushes 8'hA5 then 8'h3C; host IOR at 0x300 twice, then a third time -> returns A5, 3C, then FF; STATUS bit0 ends 0.
- WAIT=3; IOW 0x300 with 8'h77 -> io_channel_ready low exactly 3 clocks; tx_data=77 and tx_empty=0 after commit.
- IOW 0x301 while address_enable_n=0 -> ignored; data_bus_ext_oe never asserts; no register changes.
- CTRL=3'b101 (dma_en, dir=0, irq_en), RX holds 2 bytes; DACK/IOR cycles with TC on the second -> DRQ re-asserts between transfers; after the second commit dma_en=0, tc_seen=1, interrupt_request=1; CTRL write 8'h08 -> IRQ drops.
- dir=1, TX holds DEPTH-1 bytes; two DMA IOW cycles -> first accepted, DRQ then low (full), second dropped with overflow=1.
- Reset asserted while IOR is low with DACK low -> no pop after reset; the strobe's subsequent rising edge commits nothing; all outputs at reset values.
